// File: rtl/alu_mul_sequencer.sv
// Multi-cycle unsigned WIDTH x WIDTH -> low-WIDTH multiplier that drives a shared ARMALU in ADD
// mode, one shift-and-add step per cycle, stopping early once no multiplier bits remain.
module alu_mul_sequencer #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned CNT_W = 7
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] product,
  output logic             prod_negative,
  output logic             prod_zero,
  output logic             prod_overflow,
  output logic [WIDTH-1:0] alu_A,
  output logic [WIDTH-1:0] alu_B,
  output logic [2:0]       alu_cntrl,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_carry_out
);

  localparam logic [2:0] CntrlPassB = 3'b000;
  localparam logic [2:0] CntrlAdd   = 3'b010;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               lost_q, lost_d;
  logic               ovf_q, ovf_d;
  logic [WIDTH-1:0]   product_q, product_d;
  logic               prod_ovf_q, prod_ovf_d;
  logic               prod_zero_q, prod_zero_d;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    cnt_d       = cnt_q;
    lost_d      = lost_q;
    ovf_d       = ovf_q;
    product_d   = product_q;
    prod_ovf_d  = prod_ovf_q;
    prod_zero_d = prod_zero_q;
    ready       = 1'b0;
    done        = 1'b0;
    alu_A       = '0;
    alu_B       = '0;
    alu_cntrl   = CntrlPassB;

    unique case (state_q)
      StIdle: begin
        ready = 1'b1;
        if (start) begin
          mcand_d  = op_a;
          mplier_d = op_b;
          acc_d    = '0;
          cnt_d    = '0;
          lost_d   = 1'b0;
          ovf_d    = 1'b0;
          state_d  = StRun;
        end
      end
      StRun: begin
        alu_A     = acc_q;
        alu_B     = mcand_q;
        alu_cntrl = CntrlAdd;
        // A set multiplier bit whose shifted multiplicand already dropped a one overflows too
        if (mplier_q[0]) begin
          acc_d = alu_result;
          ovf_d = ovf_q | alu_carry_out | lost_q;
        end
        mcand_d  = mcand_q << 1;
        lost_d   = lost_q | mcand_q[WIDTH-1];
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (mplier_d == '0 || cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d     = StDone;
          product_d   = acc_d;
          prod_ovf_d  = ovf_d;
          prod_zero_d = (acc_d == '0);
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      cnt_q       <= '0;
      lost_q      <= 1'b0;
      ovf_q       <= 1'b0;
      product_q   <= '0;
      prod_ovf_q  <= 1'b0;
      prod_zero_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      cnt_q       <= cnt_d;
      lost_q      <= lost_d;
      ovf_q       <= ovf_d;
      product_q   <= product_d;
      prod_ovf_q  <= prod_ovf_d;
      prod_zero_q <= prod_zero_d;
    end
  end

  // Zero flag is registered so that it reads 0 out of reset rather than tracking product == 0
  assign product       = product_q;
  assign prod_negative = product_q[WIDTH-1];
  assign prod_zero     = prod_zero_q;
  assign prod_overflow = prod_ovf_q;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Self-checking bench for alu_mul_sequencer: directed corner cases plus random back-to-back
// multiplies compared against 128-bit arithmetic, with a behavioural ARMALU beside the DUT.
module tb_alu_mul_sequencer;
  localparam int unsigned W = 64;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         start;
  logic [W-1:0] op_a, op_b;
  logic         ready, done;
  logic [W-1:0] product;
  logic         prod_negative, prod_zero, prod_overflow;
  logic [W-1:0] alu_A, alu_B, alu_result;
  logic [2:0]   alu_cntrl;
  logic         alu_carry_out;
  logic [W:0]   alu_sum;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // ARMALU: ADD on 010, PASS_B otherwise
  always_comb begin
    alu_sum = {1'b0, alu_B};
    if (alu_cntrl == 3'b010) alu_sum = {1'b0, alu_A} + {1'b0, alu_B};
  end
  assign alu_result    = alu_sum[W-1:0];
  assign alu_carry_out = alu_sum[W];

  alu_mul_sequencer #(.WIDTH(W), .CNT_W(7)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .start         (start),
    .op_a          (op_a),
    .op_b          (op_b),
    .ready         (ready),
    .done          (done),
    .product       (product),
    .prod_negative (prod_negative),
    .prod_zero     (prod_zero),
    .prod_overflow (prod_overflow),
    .alu_A         (alu_A),
    .alu_B         (alu_B),
    .alu_cntrl     (alu_cntrl),
    .alu_result    (alu_result),
    .alu_carry_out (alu_carry_out)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Iterations needed: index of the highest set multiplier bit plus one, at least one
  function automatic int exp_iters(input logic [W-1:0] b);
    int n = 1;
    for (int i = 0; i < W; i++) if (b[i]) n = i + 1;
    return n;
  endfunction

  // Issue one multiply and check result, flags and latency. Returns #1 after an edge in IDLE.
  task automatic run_mul(input logic [W-1:0] a, input logic [W-1:0] b, input bit inject,
                         input string tag);
    logic [127:0] full;
    int           n, cyc;
    bit           seen, cntrl_ok;
    full = {64'b0, a} * {64'b0, b};
    n    = exp_iters(b);
    cyc  = 0;
    while (!ready && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    check($sformatf("%s.ready", tag), 128'(ready), 128'd1);
    start = 1'b1;
    op_a  = a;
    op_b  = b;
    @(posedge clk); #1;
    start = 1'b0;
    op_a  = ~a;
    op_b  = {$urandom, $urandom};
    cyc      = 1;
    seen     = 1'b0;
    cntrl_ok = 1'b1;
    while (cyc <= W + 8) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (alu_cntrl != 3'b010 || ready) cntrl_ok = 1'b0;
      if (inject && cyc == 2) begin
        start = 1'b1;
        op_a  = 64'd9;
        op_b  = 64'd3;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    check($sformatf("%s.done_seen", tag), 128'(seen), 128'd1);
    check($sformatf("%s.latency", tag), 128'(cyc), 128'(n + 1));
    check($sformatf("%s.run_cntrl", tag), 128'(cntrl_ok), 128'd1);
    check($sformatf("%s.product", tag), 128'(product), 128'(full[63:0]));
    check($sformatf("%s.ovf", tag), 128'(prod_overflow), 128'(full[127:64] != 0));
    check($sformatf("%s.neg", tag), 128'(prod_negative), 128'(full[63]));
    check($sformatf("%s.zero", tag), 128'(prod_zero), 128'(full[63:0] == 0));
    check($sformatf("%s.done_cntrl", tag), 128'(alu_cntrl), 128'd0);
    @(posedge clk); #1;
    check($sformatf("%s.idle_after", tag), 128'({ready, done}), 128'b10);
    check($sformatf("%s.hold", tag), 128'(product), 128'(full[63:0]));
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    int           pulses;
    reset_n = 1'b0;
    start   = 1'b0;
    op_a    = '0;
    op_b    = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.ready", 128'(ready), 128'd1);
    check("rst.done", 128'(done), 128'd0);
    check("rst.product", 128'(product), 128'd0);
    check("rst.flags", 128'({prod_negative, prod_zero, prod_overflow}), 128'd0);
    check("rst.cntrl", 128'(alu_cntrl), 128'd0);
    check("rst.alu_ab", 128'({alu_A, alu_B}), 128'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    run_mul(64'd3, 64'd5, 1'b0, "mul3x5");
    run_mul(64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b0, "ones_x2");
    run_mul(64'h8000_0000_0000_0000, 64'd1, 1'b0, "msb_x1");
    run_mul(64'd12345, 64'd0, 1'b0, "b_zero");
    run_mul(64'd1, 64'h8000_0000_0000_0001, 1'b0, "n64");
    run_mul(64'd0, 64'hDEAD_BEEF, 1'b0, "a_zero");
    run_mul(64'd7, 64'hFF, 1'b1, "ignore_start");

    // Reset mid-RUN abandons the multiply without a done pulse
    start = 1'b1;
    op_a  = 64'd5;
    op_b  = 64'hFFFF;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("midrst.busy", 128'(ready), 128'd0);
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    check("midrst.ready", 128'(ready), 128'd1);
    check("midrst.product", 128'(product), 128'd0);
    check("midrst.cntrl", 128'(alu_cntrl), 128'd0);
    pulses = 0;
    for (int i = 0; i < 24; i++) begin
      if (done) pulses++;
      @(posedge clk); #1;
    end
    check("midrst.no_done", 128'(pulses), 128'd0);

    for (int t = 0; t < 200; t++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      ra = ra >> $urandom_range(0, 63);
      rb = rb >> $urandom_range(0, 63);
      run_mul(ra, rb, 1'b0, $sformatf("rnd%0d", t));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
